// File: rtl/ef_gpio_pkg.sv
// Shared encodings and helpers for the GPIO interrupt block.
package ef_gpio_pkg;

    // Per-pin interrupt condition selector
    localparam logic [1:0] IRQ_HIGH = 2'b00;
    localparam logic [1:0] IRQ_LOW  = 2'b01;
    localparam logic [1:0] IRQ_RISE = 2'b10;
    localparam logic [1:0] IRQ_FALL = 2'b11;

    // Select the interrupt condition for one pin from its filtered level and edges
    function automatic logic irq_cond(input logic [1:0] irq_type,
                                      input logic       filt,
                                      input logic       rise,
                                      input logic       fall);
        logic cond;
        case (irq_type)
            IRQ_HIGH: cond = filt;
            IRQ_LOW:  cond = ~filt;
            IRQ_RISE: cond = rise;
            default:  cond = fall;
        endcase
        return cond;
    endfunction

endpackage

// File: rtl/ef_gpio_pin.sv
// One GPIO input pin: synchroniser chain, optional debounce filter,
// edge detection on the filtered value and a sticky interrupt status flop.
module ef_gpio_pin
    import ef_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_pad,
    input  logic            i_db_en,
    input  logic [DB_W-1:0] i_db_period,
    input  logic [1:0]      i_irq_type,
    input  logic            i_irq_clr,
    output logic            o_filt,
    output logic            o_ris
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [DB_W-1:0]        r_cnt;
    logic                   r_ris;

    logic w_sync;
    logic w_filt;
    logic w_rise;
    logic w_fall;
    logic w_cond;

    assign w_sync = r_sync[SYNC_STAGES-1];
    // With debounce off the filtered value is the synchroniser output itself
    assign w_filt = i_db_en ? r_filt : w_sync;
    assign w_rise = w_filt & ~r_filt_d;
    assign w_fall = ~w_filt & r_filt_d;
    assign w_cond = irq_cond(i_irq_type, w_filt, w_rise, w_fall);

    // Metastability chain for the asynchronous pad input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
        end
    end

    // Debounce: the filtered value only follows sync after it differs for db_period+1 cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_cnt  <= '0;
        end else if (!i_db_en) begin
            // Track sync so re-enabling the filter starts from the current level
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == i_db_period) begin
            r_filt <= w_sync;
            r_cnt  <= '0;
        end else begin
            r_cnt  <= r_cnt + DB_W'(1);
        end
    end

    // Previous filtered value for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d <= 1'b0;
        end else begin
            r_filt_d <= w_filt;
        end
    end

    // Sticky raw status: a new condition wins over a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ris <= 1'b0;
        end else if (w_cond) begin
            r_ris <= 1'b1;
        end else if (i_irq_clr) begin
            r_ris <= 1'b0;
        end
    end

    assign o_filt = w_filt;
    assign o_ris  = r_ris;

endmodule

// File: rtl/ef_gpio_irq.sv
// GPIO port between pads and the register block: output pass-through,
// per-pin filtered inputs and interrupt status with a single combined irq.
module ef_gpio_irq
    import ef_gpio_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   io_in,
    output logic [WIDTH-1:0]   io_out,
    output logic [WIDTH-1:0]   io_oe,
    input  logic [WIDTH-1:0]   bus_out,
    input  logic [WIDTH-1:0]   bus_oe,
    output logic [WIDTH-1:0]   bus_in,
    input  logic [WIDTH-1:0]   db_en,
    input  logic [DB_W-1:0]    db_period,
    input  logic [2*WIDTH-1:0] irq_type,
    input  logic [WIDTH-1:0]   irq_en,
    input  logic [WIDTH-1:0]   irq_clr,
    output logic [WIDTH-1:0]   ris,
    output logic [WIDTH-1:0]   mis,
    output logic               irq
);

    logic [WIDTH-1:0] w_filt;
    logic [WIDTH-1:0] w_ris;

    // Output side is a straight pass-through to the pads
    assign io_out = bus_out;
    assign io_oe  = bus_oe;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pin
            ef_gpio_pin #(
                .SYNC_STAGES(SYNC_STAGES),
                .DB_W       (DB_W)
            ) u_pin (
                .clk        (clk),
                .rst_n      (rst_n),
                .i_pad      (io_in[gi]),
                .i_db_en    (db_en[gi]),
                .i_db_period(db_period),
                .i_irq_type (irq_type[2*gi +: 2]),
                .i_irq_clr  (irq_clr[gi]),
                .o_filt     (w_filt[gi]),
                .o_ris      (w_ris[gi])
            );
        end
    endgenerate

    // Masking is combinational so enabling a pending pin raises irq immediately
    assign bus_in = w_filt;
    assign ris    = w_ris;
    assign mis    = w_ris & irq_en;
    assign irq    = |mis;

endmodule

// File: tb/tb_ef_gpio_irq.sv
// Scoreboard bench for ef_gpio_irq: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares them when their cycle arrives.
module tb_ef_gpio_irq;

    localparam int SIG_BUS_IN = 0;
    localparam int SIG_RIS    = 1;
    localparam int SIG_MIS    = 2;
    localparam int SIG_IRQ    = 3;
    localparam int SIG_IO_OUT = 4;
    localparam int SIG_IO_OE  = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  io_in = '0;
    logic [7:0]  io_out;
    logic [7:0]  io_oe;
    logic [7:0]  bus_out = '0;
    logic [7:0]  bus_oe = '0;
    logic [7:0]  bus_in;
    logic [7:0]  db_en = '0;
    logic [7:0]  db_period = '0;
    logic [15:0] irq_type = '0;
    logic [7:0]  irq_en = '0;
    logic [7:0]  irq_clr = '0;
    logic [7:0]  ris;
    logic [7:0]  mis;
    logic        irq;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] mask;
        logic [7:0] exp;
        string      name;
    } exp_t;

    exp_t sb_q[$];

    ef_gpio_irq #(.WIDTH(8), .SYNC_STAGES(2), .DB_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .io_in    (io_in),
        .io_out   (io_out),
        .io_oe    (io_oe),
        .bus_out  (bus_out),
        .bus_oe   (bus_oe),
        .bus_in   (bus_in),
        .db_en    (db_en),
        .db_period(db_period),
        .irq_type (irq_type),
        .irq_en   (irq_en),
        .irq_clr  (irq_clr),
        .ris      (ris),
        .mis      (mis),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] get_sig(input int s);
        case (s)
            SIG_BUS_IN: return bus_in;
            SIG_RIS:    return ris;
            SIG_MIS:    return mis;
            SIG_IRQ:    return {7'd0, irq};
            SIG_IO_OUT: return io_out;
            default:    return io_oe;
        endcase
    endfunction

    // Queue an expectation dly cycles from now, kept sorted by cycle
    task automatic expect_at(input int dly, input int sig, input logic [7:0] mask,
                             input logic [7:0] val, input string name);
        exp_t e;
        int   pos;
        e.cyc  = cyc + dly;
        e.sig  = sig;
        e.mask = mask;
        e.exp  = val;
        e.name = name;
        pos = 0;
        while (pos < sb_q.size() && sb_q[pos].cyc <= e.cyc) pos++;
        sb_q.insert(pos, e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compare every expectation due this cycle, away from the clock edge
    always @(negedge clk) begin
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            exp_t       e;
            logic [7:0] act;
            e   = sb_q.pop_front();
            act = get_sig(e.sig);
            checks++;
            if (e.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
            end else if ((act & e.mask) !== (e.exp & e.mask)) begin
                errors++;
                $display("FAIL %s: cycle %0d actual=%02h required=%02h mask=%02h",
                         e.name, cyc, act & e.mask, e.exp & e.mask, e.mask);
            end else begin
                $display("ok   %s: cycle %0d value=%02h mask=%02h", e.name, cyc, act & e.mask, e.mask);
            end
        end
    end

    initial begin
        // 1: reset holds everything at zero even with inputs toggling
        irq_en = 8'hFF;
        tick(2);
        io_in = 8'hFF;
        expect_at(2, SIG_BUS_IN, 8'hFF, 8'h00, "rst_bus_in");
        expect_at(2, SIG_RIS,    8'hFF, 8'h00, "rst_ris");
        expect_at(2, SIG_IRQ,    8'h01, 8'h00, "rst_irq");
        tick(3);
        io_in = 8'h00;
        expect_at(1, SIG_BUS_IN, 8'hFF, 8'h00, "rst_bus_in_toggle");
        tick(2);
        rst_n  = 1'b1;
        irq_en = 8'h00;
        expect_at(4, SIG_BUS_IN, 8'hFF, 8'h00, "post_rst_bus_in");
        expect_at(4, SIG_RIS,    8'hFF, 8'h00, "post_rst_ris");
        tick(5);

        // Output pass-through
        bus_out = 8'hA5;
        bus_oe  = 8'h3C;
        expect_at(0, SIG_IO_OUT, 8'hFF, 8'hA5, "io_out_pass");
        expect_at(0, SIG_IO_OE,  8'hFF, 8'h3C, "io_oe_pass");
        tick(1);

        // 2: synchroniser latency of exactly two cycles; high level sets ris one later
        io_in[3] = 1'b1;
        expect_at(1, SIG_BUS_IN, 8'h08, 8'h00, "sync_lat_m1");
        expect_at(2, SIG_BUS_IN, 8'h08, 8'h08, "sync_lat");
        expect_at(2, SIG_RIS,    8'h08, 8'h00, "hilvl_ris_pre");
        expect_at(3, SIG_RIS,    8'h08, 8'h08, "hilvl_ris");
        tick(4);

        // 3: debounce, short pulse rejected
        db_en[0]  = 1'b1;
        db_period = 8'd5;
        tick(2);
        io_in[0] = 1'b1;
        expect_at(4,  SIG_BUS_IN, 8'h01, 8'h00, "db_glitch_a");
        expect_at(8,  SIG_BUS_IN, 8'h01, 8'h00, "db_glitch_b");
        expect_at(11, SIG_BUS_IN, 8'h01, 8'h00, "db_glitch_c");
        tick(3);
        io_in[0] = 1'b0;
        tick(9);
        // stable high appears after 2+5+1 cycles
        io_in[0] = 1'b1;
        expect_at(7, SIG_BUS_IN, 8'h01, 8'h00, "db_stable_m1");
        expect_at(8, SIG_BUS_IN, 8'h01, 8'h01, "db_stable");
        tick(10);
        io_in[0] = 1'b0;
        expect_at(8, SIG_BUS_IN, 8'h01, 8'h00, "db_stable_fall");
        tick(12);
        // zero period adds one cycle
        db_period = 8'd0;
        tick(1);
        io_in[0] = 1'b1;
        expect_at(2, SIG_BUS_IN, 8'h01, 8'h00, "db_p0_m1");
        expect_at(3, SIG_BUS_IN, 8'h01, 8'h01, "db_p0");
        tick(5);
        db_en[0] = 1'b0;
        tick(2);

        // 4: rising-edge interrupt on pin 1
        irq_type[3:2] = 2'b10;
        irq_en        = 8'h02;
        tick(2);
        io_in[1] = 1'b1;
        expect_at(2, SIG_RIS, 8'h02, 8'h00, "rise_ris_pre");
        expect_at(3, SIG_RIS, 8'h02, 8'h02, "rise_ris");
        expect_at(3, SIG_IRQ, 8'h01, 8'h01, "rise_irq");
        tick(5);
        irq_clr[1] = 1'b1;
        expect_at(1, SIG_RIS, 8'h02, 8'h00, "rise_clr");
        expect_at(1, SIG_IRQ, 8'h01, 8'h00, "rise_clr_irq");
        expect_at(4, SIG_RIS, 8'h02, 8'h00, "rise_no_retrigger");
        tick(1);
        irq_clr[1] = 1'b0;
        tick(4);
        io_in[1] = 1'b0;
        tick(5);
        // clear lands on the same edge as the new rise: set wins
        io_in[1] = 1'b1;
        tick(2);
        irq_clr[1] = 1'b1;
        expect_at(1, SIG_RIS, 8'h02, 8'h02, "rise_set_wins");
        expect_at(2, SIG_RIS, 8'h02, 8'h02, "rise_set_wins_hold");
        tick(1);
        irq_clr[1] = 1'b0;
        tick(3);
        irq_clr[1] = 1'b1;
        tick(1);
        irq_clr[1] = 1'b0;
        tick(1);

        // 5: low-level interrupt on pin 2
        irq_en        = 8'h00;
        irq_type[5:4] = 2'b01;
        expect_at(1, SIG_RIS, 8'h04, 8'h04, "lowlvl_ris");
        tick(3);
        irq_clr[2] = 1'b1;
        expect_at(1, SIG_RIS, 8'h04, 8'h04, "lowlvl_clr_held");
        tick(1);
        irq_clr[2] = 1'b0;
        io_in[2]   = 1'b1;
        tick(4);
        irq_clr[2] = 1'b1;
        expect_at(1, SIG_RIS, 8'h04, 8'h00, "lowlvl_clr");
        tick(1);
        irq_clr[2] = 1'b0;
        tick(2);

        // 6: masked falling edge on pin 7, then unmask
        irq_type[15:14] = 2'b11;
        tick(1);
        io_in[7] = 1'b1;
        expect_at(4, SIG_RIS, 8'h80, 8'h00, "fall_no_rise");
        tick(5);
        io_in[7] = 1'b0;
        expect_at(3, SIG_RIS, 8'h80, 8'h80, "fall_ris");
        expect_at(3, SIG_MIS, 8'h80, 8'h00, "fall_mis_masked");
        expect_at(3, SIG_IRQ, 8'h01, 8'h00, "fall_irq_masked");
        tick(5);
        irq_en[7] = 1'b1;
        expect_at(0, SIG_MIS, 8'h80, 8'h80, "unmask_mis");
        expect_at(0, SIG_IRQ, 8'h01, 8'h01, "unmask_irq");
        tick(3);

        // Drain the scoreboard with a bounded wait
        for (int k = 0; k < 100 && sb_q.size() > 0; k++) @(posedge clk);
        if (sb_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
